// File: rtl/decode_stage_pipe_pkg.sv
// Shared definitions for the RV32I decode stage.
//   op_e       : internal operation codes (NOP plus the 37 RV32I ops used by EX)
//   OPC_*      : RV32 major opcode values (inst[6:0])
//   ZERO_WORD  : all-zero datapath word
package decode_stage_pipe_pkg;

  localparam int OP_W = 6;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 6'd0,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/decode_stage_pipe_decode_comb.sv
// Pure combinational RV32I instruction decoder.
// Ports:
//   inst      in   32-bit instruction word
//   op        out  decoded operation (OP_NOP when illegal)
//   imm       out  sign-extended immediate (shamt zero-extended for shifts)
//   rd        out  destination register (0 for branch/store/illegal)
//   we        out  writes rd (never for x0)
//   uses_rs1  out  rs1 is a real source operand
//   uses_rs2  out  rs2 is a real source operand
//   illegal   out  unknown opcode/funct3/funct7 combination
module decode_comb
  import decode_stage_pipe_pkg::*;
(
  input  logic [31:0] inst,
  output op_e         op,
  output logic [31:0] imm,
  output logic [4:0]  rd,
  output logic        we,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        illegal
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic        has_rd;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];

  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'h000};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_sh = {27'd0, inst[24:20]};

  always_comb begin
    op       = OP_NOP;
    imm      = ZERO_WORD;
    has_rd   = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    illegal  = 1'b0;

    case (opcode)
      OPC_LUI:   begin op = OP_LUI;   imm = imm_u; has_rd = 1'b1; end
      OPC_AUIPC: begin op = OP_AUIPC; imm = imm_u; has_rd = 1'b1; end
      OPC_JAL:   begin op = OP_JAL;   imm = imm_j; has_rd = 1'b1; end
      OPC_JALR: begin
        op = OP_JALR; imm = imm_i; has_rd = 1'b1; uses_rs1 = 1'b1;
        if (f3 != 3'b000) illegal = 1'b1;
      end
      OPC_BRANCH: begin
        imm = imm_b; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        case (f3)
          3'b000:  op = OP_BEQ;
          3'b001:  op = OP_BNE;
          3'b100:  op = OP_BLT;
          3'b101:  op = OP_BGE;
          3'b110:  op = OP_BLTU;
          3'b111:  op = OP_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        imm = imm_i; has_rd = 1'b1; uses_rs1 = 1'b1;
        case (f3)
          3'b000:  op = OP_LB;
          3'b001:  op = OP_LH;
          3'b010:  op = OP_LW;
          3'b100:  op = OP_LBU;
          3'b101:  op = OP_LHU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        imm = imm_s; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        case (f3)
          3'b000:  op = OP_SB;
          3'b001:  op = OP_SH;
          3'b010:  op = OP_SW;
          default: illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        imm = imm_i; has_rd = 1'b1; uses_rs1 = 1'b1;
        case (f3)
          3'b000: op = OP_ADDI;
          3'b010: op = OP_SLTI;
          3'b011: op = OP_SLTIU;
          3'b100: op = OP_XORI;
          3'b110: op = OP_ORI;
          3'b111: op = OP_ANDI;
          3'b001: begin
            imm = imm_sh;
            if (f7 == F7_ZERO) op = OP_SLLI;
            else               illegal = 1'b1;
          end
          default: begin
            imm = imm_sh;
            if      (f7 == F7_ZERO) op = OP_SRLI;
            else if (f7 == F7_ALT)  op = OP_SRAI;
            else                    illegal = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        has_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding.
        if (f7 == F7_ZERO) begin
          case (f3)
            3'b000:  op = OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
          endcase
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          op = OP_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          op = OP_SRA;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase

    // Illegal instructions become an inert NOP that EX traps on.
    if (illegal) begin
      op       = OP_NOP;
      imm      = ZERO_WORD;
      has_rd   = 1'b0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
    end
  end

  assign rd = has_rd ? inst[11:7] : 5'd0;
  assign we = has_rd && (inst[11:7] != 5'd0);

endmodule

// File: rtl/decode_stage_pipe.sv
// RV32I decode stage: decodes the IF/ID instruction, reads and forwards
// operands, stalls on load-use hazards and registers results into an
// ID/EX slot with a valid/ready handshake. Flush kills the slot.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush                     kill slot contents and current input
//   in_valid/in_ready         IF/ID handshake, in_pc/in_inst payload
//   rf_raddr1/2, rf_rdata1/2  register file read port (same-cycle data)
//   fwd_valid/fwd_rd/fwd_data forwarding entries, index 0 highest priority
//   ld_pend, ld_rd            outstanding load in EX
//   out_valid/out_ready       ID/EX handshake
//   out_pc/imm/rs1/rs2/rd/we/op/illegal  decoded slot contents
module decode_stage_pipe
  import decode_stage_pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RA_W      = 5,
  parameter int FWD_PORTS = 2,
  parameter int OP_WIDTH  = OP_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [31:0]               in_inst,
  output logic [RA_W-1:0]           rf_raddr1,
  output logic [RA_W-1:0]           rf_raddr2,
  input  logic [XLEN-1:0]           rf_rdata1,
  input  logic [XLEN-1:0]           rf_rdata2,
  input  logic [FWD_PORTS-1:0]      fwd_valid,
  input  logic [FWD_PORTS*RA_W-1:0] fwd_rd,
  input  logic [FWD_PORTS*XLEN-1:0] fwd_data,
  input  logic                      ld_pend,
  input  logic [RA_W-1:0]           ld_rd,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [XLEN-1:0]           out_imm,
  output logic [XLEN-1:0]           out_rs1,
  output logic [XLEN-1:0]           out_rs2,
  output logic [RA_W-1:0]           out_rd,
  output logic                      out_we,
  output logic [OP_WIDTH-1:0]       out_op,
  output logic                      out_illegal
);

  op_e              dec_op;
  logic [31:0]      dec_imm;
  logic [4:0]       dec_rd;
  logic             dec_we, dec_uses_rs1, dec_uses_rs2, dec_illegal;
  logic [RA_W-1:0]  rs1, rs2;
  logic [XLEN-1:0]  rs1_val, rs2_val;
  logic             hazard, accept;

  decode_comb u_decode_comb (
    .inst     (in_inst),
    .op       (dec_op),
    .imm      (dec_imm),
    .rd       (dec_rd),
    .we       (dec_we),
    .uses_rs1 (dec_uses_rs1),
    .uses_rs2 (dec_uses_rs2),
    .illegal  (dec_illegal)
  );

  assign rs1       = in_inst[19:15];
  assign rs2       = in_inst[24:20];
  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  // Walk from oldest to youngest so the lowest matching index wins.
  function automatic logic [XLEN-1:0] pick_operand(
    input logic                      used,
    input logic [RA_W-1:0]           rs,
    input logic [XLEN-1:0]           rf,
    input logic [FWD_PORTS-1:0]      fv,
    input logic [FWD_PORTS*RA_W-1:0] fr,
    input logic [FWD_PORTS*XLEN-1:0] fd
  );
    logic [XLEN-1:0] val;
    val = '0;
    if (used && rs != '0) begin
      val = rf;
      for (int p = FWD_PORTS - 1; p >= 0; p--) begin
        if (fv[p] && fr[p*RA_W +: RA_W] == rs) val = fd[p*XLEN +: XLEN];
      end
    end
    return val;
  endfunction

  always_comb begin
    rs1_val = pick_operand(dec_uses_rs1, rs1, rf_rdata1, fwd_valid, fwd_rd, fwd_data);
    rs2_val = pick_operand(dec_uses_rs2, rs2, rf_rdata2, fwd_valid, fwd_rd, fwd_data);
  end

  assign hazard = ld_pend && (ld_rd != '0) &&
                  ((dec_uses_rs1 && rs1 == ld_rd) || (dec_uses_rs2 && rs2 == ld_rd));

  assign in_ready = !rst && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_imm     <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_we      <= 1'b0;
      out_op      <= OP_WIDTH'(OP_NOP);
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_imm     <= XLEN'(dec_imm);
      out_rs1     <= rs1_val;
      out_rs2     <= rs2_val;
      out_rd      <= RA_W'(dec_rd);
      out_we      <= dec_we;
      out_op      <= OP_WIDTH'(dec_op);
      out_illegal <= dec_illegal;
    end else if (!out_valid || out_ready) begin
      // Slot consumed with nothing to replace it (idle or hazard bubble).
      out_valid <= 1'b0;
    end
  end

endmodule
